// File: rtl/cdb_broadcast_pkg.sv
// Shared types for the complete-stage broadcast bus: FU results, writeback lanes
// and the three-tag CDB packet consumed by the reservation stations.
package cdb_broadcast_pkg;

    localparam int PR        = 6;  // physical register tag width
    localparam int CDB_WIDTH = 3;  // broadcast lanes, one per tag field of cdb_t_t

    typedef logic [PR-1:0] pr_t;

    typedef struct packed {
        logic        valid;
        pr_t         dest_pr;
        logic [31:0] value;
    } fu_result_t;

    typedef struct packed {
        logic        valid;
        pr_t         dest_pr;
        logic [31:0] value;
    } wb_t;

    // Tag 0 on a field means that lane is idle.
    typedef struct packed {
        pr_t t0;
        pr_t t1;
        pr_t t2;
    } cdb_t_t;

endpackage

// File: rtl/cdb_broadcast_if.sv
// FU-facing and RS-facing signals of the broadcast block. The slave modport is
// the broadcast block itself; the master modport is the FU/consumer side.
interface cdb_broadcast_if #(
    parameter int NUM_FU = 5
);
    import cdb_broadcast_pkg::*;

    fu_result_t [NUM_FU-1:0]    fu_result;
    logic       [NUM_FU-1:0]    fu_ready;
    cdb_t_t                     cdb_t;
    wb_t        [CDB_WIDTH-1:0] wb_out;

    modport master (output fu_result, input fu_ready, cdb_t, wb_out);
    modport slave  (input fu_result, output fu_ready, cdb_t, wb_out);

endinterface

// File: rtl/cdb_broadcast_rr_pick3.sv
// Round-robin picker: starting at rr_ptr, grants the first three occupied slots
// in scan order. Returns one-hot grants per lane, lane-valid bits and the
// pointer value that follows the last granted slot.
module cdb_broadcast_rr_pick3
    import cdb_broadcast_pkg::*;
#(
    parameter int NUM_FU = 5
) (
    input  logic [NUM_FU-1:0]                 occupied,
    input  logic [$clog2(NUM_FU)-1:0]         rr_ptr,
    output logic [CDB_WIDTH-1:0][NUM_FU-1:0]  gnt,
    output logic [CDB_WIDTH-1:0]              gnt_vld,
    output logic [$clog2(NUM_FU)-1:0]         nxt_ptr
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                rot;
    logic [CDB_WIDTH-1:0][NUM_FU-1:0] g_rot;
    logic [2*NUM_FU-1:0]              ext;
    logic [1:0]                       cnt;
    int                               last_k;
    int                               sum;

    // Rotate so rr_ptr sits at bit 0, pick in order, then rotate grants back.
    always_comb begin
        rot     = NUM_FU'({occupied, occupied} >> rr_ptr);
        g_rot   = '0;
        gnt_vld = '0;
        gnt     = '0;
        ext     = '0;
        cnt     = 2'd0;
        last_k  = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (rot[k] && cnt != 2'd3) begin
                g_rot[cnt][k] = 1'b1;
                gnt_vld[cnt]  = 1'b1;
                cnt           = cnt + 2'd1;
                last_k        = k;
            end
        end
        for (int l = 0; l < CDB_WIDTH; l++) begin
            ext    = {{NUM_FU{1'b0}}, g_rot[l]} << rr_ptr;
            gnt[l] = ext[NUM_FU-1:0] | ext[2*NUM_FU-1:NUM_FU];
        end
        sum = int'(rr_ptr) + last_k + 1;
        if (sum >= NUM_FU) sum = sum - NUM_FU;
        nxt_ptr = PTR_W'(sum);
    end

endmodule

// File: rtl/cdb_broadcast.sv
// Complete-stage CDB producer: one holding slot per FU, up to three broadcasts
// per cycle in round-robin order, per-FU back-pressure. A slot being broadcast
// this cycle can take a new result at the same edge, so an FU can stream.
module cdb_broadcast
    import cdb_broadcast_pkg::*;
#(
    parameter int NUM_FU = 5
) (
    input  logic          clock,
    input  logic          reset,
    cdb_broadcast_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                occ_q, occ_d;
    pr_t  [NUM_FU-1:0]                pr_q, pr_d;
    logic [NUM_FU-1:0][31:0]          val_q, val_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;

    logic [CDB_WIDTH-1:0][NUM_FU-1:0] gnt;
    logic [CDB_WIDTH-1:0]             gnt_vld;
    logic [PTR_W-1:0]                 nxt_ptr;
    logic [NUM_FU-1:0]                granted;
    logic [NUM_FU-1:0]                fu_rdy;
    wb_t  [CDB_WIDTH-1:0]             wb_lane;

    cdb_broadcast_rr_pick3 #(.NUM_FU(NUM_FU)) u_pick (
        .occupied (occ_q),
        .rr_ptr   (rr_ptr_q),
        .gnt      (gnt),
        .gnt_vld  (gnt_vld),
        .nxt_ptr  (nxt_ptr)
    );

    // Slots released this cycle and the resulting back-pressure.
    always_comb begin
        granted = '0;
        for (int l = 0; l < CDB_WIDTH; l++) granted = granted | gnt[l];
        fu_rdy = reset ? '0 : (~occ_q | granted);
    end

    // Drive each lane from its granted slot; lanes are forced idle during reset.
    always_comb begin
        wb_lane = '0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (!reset && gnt_vld[l]) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (gnt[l][i]) begin
                        wb_lane[l].valid   = 1'b1;
                        wb_lane[l].dest_pr = pr_q[i];
                        wb_lane[l].value   = val_q[i];
                    end
                end
            end
        end
    end

    assign bus.fu_ready = fu_rdy;
    assign bus.wb_out   = wb_lane;
    assign bus.cdb_t.t0 = wb_lane[0].dest_pr;
    assign bus.cdb_t.t1 = wb_lane[1].dest_pr;
    assign bus.cdb_t.t2 = wb_lane[2].dest_pr;

    // Release granted slots, capture accepted results (tag 0 is dropped), advance pointer.
    always_comb begin
        occ_d    = occ_q & ~granted;
        pr_d     = pr_q;
        val_d    = val_q;
        rr_ptr_d = gnt_vld[0] ? nxt_ptr : rr_ptr_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (bus.fu_result[i].valid && fu_rdy[i] && bus.fu_result[i].dest_pr != '0) begin
                occ_d[i] = 1'b1;
                pr_d[i]  = bus.fu_result[i].dest_pr;
                val_d[i] = bus.fu_result[i].value;
            end
        end
    end

    // Slot and pointer registers; reset empties every slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q    <= '0;
            pr_q     <= '0;
            val_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            occ_q    <= occ_d;
            pr_q     <= pr_d;
            val_q    <= val_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: directed table of cycles with fixed expectations,
// then random FU traffic checked against a slot/queue reference model.
module tb_cdb_broadcast;
    import cdb_broadcast_pkg::*;

    localparam int NF = 5;

    logic clock;
    logic reset;

    cdb_broadcast_if #(.NUM_FU(NF)) bus ();

    cdb_broadcast #(.NUM_FU(NF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // FU-side drive state
    bit        in_v   [NF];
    bit [5:0]  in_pr  [NF];
    bit [31:0] in_val [NF];

    // reference model state
    bit        m_occ [NF];
    bit [5:0]  m_pr  [NF];
    bit [31:0] m_val [NF];
    int        m_ptr = 0;
    bit        e_gnt [NF];
    bit [4:0]  e_rdy;
    bit [38:0] e_wb  [3];
    int        e_n, e_last;

    typedef struct {
        bit        rst;
        bit [4:0]  vld;
        bit [5:0]  pr_base;
        bit [31:0] val_base;
        bit [4:0]  e_rdy;
        bit [5:0]  e_t0, e_t1, e_t2;
        int        e_ptr;
    } vec_t;

    vec_t tbl [22];
    vec_t none;

    function automatic vec_t mk(bit rst, bit [4:0] vld, bit [5:0] pb, bit [31:0] vb,
                                bit [4:0] rdy, bit [5:0] a, bit [5:0] b, bit [5:0] c, int p);
        vec_t v;
        v.rst = rst; v.vld = vld; v.pr_base = pb; v.val_base = vb;
        v.e_rdy = rdy; v.e_t0 = a; v.e_t1 = b; v.e_t2 = c; v.e_ptr = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NF; i++) begin
            bus.fu_result[i].valid   = in_v[i];
            bus.fu_result[i].dest_pr = in_pr[i];
            bus.fu_result[i].value   = in_val[i];
        end
    endtask

    // Expected outputs this cycle: occupied slots in scan order from the pointer, first three win.
    task automatic model_comb(input bit rst);
        int idx;
        e_rdy = '0; e_n = 0; e_last = 0;
        for (int i = 0; i < NF; i++) e_gnt[i] = 0;
        for (int l = 0; l < 3; l++) e_wb[l] = '0;
        if (!rst) begin
            for (int k = 0; k < NF; k++) begin
                idx = (m_ptr + k) % NF;
                if (m_occ[idx] && e_n < 3) begin
                    e_wb[e_n] = {1'b1, m_pr[idx], m_val[idx]};
                    e_gnt[idx] = 1;
                    e_last = idx;
                    e_n++;
                end
            end
            for (int i = 0; i < NF; i++) e_rdy[i] = !m_occ[i] || e_gnt[i];
        end
    endtask

    task automatic model_clk(input bit rst);
        if (rst) begin
            for (int i = 0; i < NF; i++) m_occ[i] = 0;
            m_ptr = 0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (e_gnt[i]) m_occ[i] = 0;
                if (in_v[i] && e_rdy[i] && in_pr[i] != 0) begin
                    m_occ[i] = 1; m_pr[i] = in_pr[i]; m_val[i] = in_val[i];
                end
            end
            if (e_n > 0) m_ptr = (e_last + 1) % NF;
        end
    endtask

    task automatic run_cycle(input bit use_tbl, input vec_t r);
        bit dup;
        model_comb(reset);
        #1;
        chk("ready", 64'(bus.fu_ready), 64'(e_rdy));
        for (int l = 0; l < 3; l++)
            chk($sformatf("wb_lane%0d", l), 64'(bus.wb_out[l]), 64'(e_wb[l]));
        dup = (bus.cdb_t.t0 != 0 && (bus.cdb_t.t0 == bus.cdb_t.t1 || bus.cdb_t.t0 == bus.cdb_t.t2)) ||
              (bus.cdb_t.t1 != 0 && bus.cdb_t.t1 == bus.cdb_t.t2);
        chk("distinct_tags", 64'(dup), 64'(0));
        if (use_tbl) begin
            chk("tbl_ready", 64'(bus.fu_ready), 64'(r.e_rdy));
            chk("tbl_tags", 64'({bus.cdb_t.t0, bus.cdb_t.t1, bus.cdb_t.t2}),
                64'({r.e_t0, r.e_t1, r.e_t2}));
            if (r.e_ptr >= 0) chk("tbl_rr_ptr", 64'(dut.rr_ptr_q), 64'(r.e_ptr));
        end
        @(posedge clock);
        model_clk(reset);
        #1;
    endtask

    function automatic bit in_use(bit [5:0] p);
        for (int i = 0; i < NF; i++)
            if ((in_v[i] && in_pr[i] == p) || (m_occ[i] && m_pr[i] == p)) return 1;
        return 0;
    endfunction

    function automatic bit [5:0] pick_pr();
        bit [5:0] p;
        if ($urandom_range(0, 7) == 0) return 6'd0;
        for (int t = 0; t < 200; t++) begin
            p = 6'($urandom_range(1, 63));
            if (!in_use(p)) return p;
        end
        return 6'd0;
    endfunction

    initial begin
        //              rst  vld       base   vbase          rdy       t0     t1     t2    ptr
        tbl[0]  = mk(1, 5'b00000, 6'd0,  32'h0,     5'b00000, 6'd0,  6'd0,  6'd0,  0);
        tbl[1]  = mk(1, 5'b00000, 6'd0,  32'h0,     5'b00000, 6'd0,  6'd0,  6'd0,  0);
        tbl[2]  = mk(0, 5'b00100, 6'd5,  32'hABCB,  5'b11111, 6'd0,  6'd0,  6'd0,  0);
        tbl[3]  = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd7,  6'd0,  6'd0,  0);
        tbl[4]  = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  3);
        tbl[5]  = mk(1, 5'b00000, 6'd0,  32'h0,     5'b00000, 6'd0,  6'd0,  6'd0,  -1);
        tbl[6]  = mk(0, 5'b11111, 6'd10, 32'h100,   5'b11111, 6'd0,  6'd0,  6'd0,  0);
        tbl[7]  = mk(0, 5'b00000, 6'd0,  32'h0,     5'b00111, 6'd10, 6'd11, 6'd12, 0);
        tbl[8]  = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd13, 6'd14, 6'd0,  3);
        tbl[9]  = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  0);
        tbl[10] = mk(0, 5'b00010, 6'd19, 32'h200,   5'b11111, 6'd0,  6'd0,  6'd0,  0);
        tbl[11] = mk(0, 5'b00010, 6'd20, 32'h210,   5'b11111, 6'd20, 6'd0,  6'd0,  0);
        tbl[12] = mk(0, 5'b00010, 6'd21, 32'h220,   5'b11111, 6'd21, 6'd0,  6'd0,  2);
        tbl[13] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd22, 6'd0,  6'd0,  2);
        tbl[14] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  2);
        tbl[15] = mk(0, 5'b01000, 6'd61, 32'h300,   5'b11111, 6'd0,  6'd0,  6'd0,  2);
        tbl[16] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  2);
        tbl[17] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  2);
        tbl[18] = mk(0, 5'b11111, 6'd10, 32'h400,   5'b11111, 6'd0,  6'd0,  6'd0,  2);
        tbl[19] = mk(1, 5'b00000, 6'd0,  32'h0,     5'b00000, 6'd0,  6'd0,  6'd0,  -1);
        tbl[20] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  0);
        tbl[21] = mk(0, 5'b00000, 6'd0,  32'h0,     5'b11111, 6'd0,  6'd0,  6'd0,  0);
        none = mk(0, 5'b0, 6'd0, 32'h0, 5'b0, 6'd0, 6'd0, 6'd0, -1);

        reset = 1'b1;
        for (int i = 0; i < NF; i++) begin in_v[i] = 0; in_pr[i] = 0; in_val[i] = 0; end
        apply();
        @(posedge clock);
        #1;

        // directed cycles
        for (int r = 0; r < 22; r++) begin
            reset = tbl[r].rst;
            for (int i = 0; i < NF; i++) begin
                in_v[i]   = tbl[r].vld[i];
                in_pr[i]  = tbl[r].vld[i] ? 6'(tbl[r].pr_base + 6'(i)) : 6'd0;
                in_val[i] = tbl[r].val_base + 32'(i);
            end
            apply();
            run_cycle(1, tbl[r]);
        end

        // random traffic; each FU holds its result until accepted
        for (int i = 0; i < NF; i++) in_v[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NF; i++) begin
                if (!in_v[i] && $urandom_range(0, 2) != 0) begin
                    in_pr[i]  = pick_pr();
                    in_val[i] = $urandom;
                    in_v[i]   = 1;
                end
            end
            apply();
            run_cycle(0, none);
            for (int i = 0; i < NF; i++)
                if (in_v[i] && e_rdy[i]) in_v[i] = 0;
        end

        // drain
        reset = 1'b0;
        for (int i = 0; i < NF; i++) in_v[i] = 0;
        apply();
        for (int c = 0; c < 4; c++) run_cycle(0, none);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
